// File: rtl/div_unit.sv
// Purpose: radix-2 restoring 32-bit divider for MIPS DIV/DIVU, result as {remainder, quotient}.
// Latency: ready pulses 33 cycles after accept (2 cycles for divide-by-zero); annul aborts in flight.
// Backpressure: holds EX via combinational stall_req until the ready cycle; starts outside IDLE are ignored.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  state_t             state;
  state_t             nextState;
  logic [CW-1:0]      iterCnt;
  logic [2*WIDTH:0]   workReg;
  logic [2*WIDTH-1:0] resultReg;
  logic [WIDTH-1:0]   divisorMag;
  logic [WIDTH-1:0]   dividendRaw;
  logic               quotNeg;
  logic               remNeg;

  logic               accept;
  logic               lastIter;
  logic [WIDTH-1:0]   dividendMagIn;
  logic [WIDTH-1:0]   divisorMagIn;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     trialHi;
  logic [WIDTH:0]     diffHi;
  logic               canSub;
  logic [2*WIDTH:0]   stepWork;
  logic [WIDTH-1:0]   quotRaw;
  logic [WIDTH-1:0]   remRaw;
  logic [2*WIDTH-1:0] finalResult;

  assign accept   = (state == IDLE) & start & ~annul;
  assign lastIter = (iterCnt == CW'(WIDTH - 1));

  // Magnitudes of the incoming operands; only signed mode folds negatives
  assign dividendMagIn = (signed_div & opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
  assign divisorMagIn  = (signed_div & opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;

  // One restoring step: shift, trial-subtract on the upper bits, shift in the quotient bit
  assign shifted  = workReg << 1;
  assign trialHi  = shifted[2*WIDTH:WIDTH];
  assign canSub   = (trialHi >= {1'b0, divisorMag});
  assign diffHi   = trialHi - {1'b0, divisorMag};
  assign stepWork = canSub ? {diffHi, shifted[WIDTH-1:1], 1'b1} : shifted;

  // Sign fix-up: quotient truncates toward zero, remainder follows the dividend
  assign quotRaw     = stepWork[WIDTH-1:0];
  assign remRaw      = stepWork[2*WIDTH-1:WIDTH];
  assign finalResult = {remNeg  ? (~remRaw + 1'b1)  : remRaw,
                        quotNeg ? (~quotRaw + 1'b1) : quotRaw};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and ready decode; annul always returns to IDLE and suppresses ready
  always_comb begin
    nextState = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          nextState = (opdata2 == '0) ? DIVZERO : ON;
        end
      end
      DIVZERO: begin
        nextState = annul ? IDLE : END;
      end
      ON: begin
        if (annul) begin
          nextState = IDLE;
        end else if (lastIter) begin
          nextState = END;
        end
      end
      END: begin
        nextState = IDLE;
        ready     = ~annul;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Operand capture, iteration and result register updates
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iterCnt     <= '0;
      workReg     <= '0;
      resultReg   <= '0;
      divisorMag  <= '0;
      dividendRaw <= '0;
      quotNeg     <= 1'b0;
      remNeg      <= 1'b0;
    end else begin
      if (accept) begin
        dividendRaw <= opdata1;
        divisorMag  <= divisorMagIn;
        quotNeg     <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
        remNeg      <= signed_div & opdata1[WIDTH-1];
        iterCnt     <= '0;
        workReg     <= {{(WIDTH+1){1'b0}}, dividendMagIn};
      end
      if ((state == ON) && !annul) begin
        workReg <= stepWork;
        iterCnt <= iterCnt + 1'b1;
        if (lastIter) begin
          resultReg <= finalResult;
        end
      end
      if ((state == DIVZERO) && !annul) begin
        resultReg <= {dividendRaw, {WIDTH{1'b1}}};
      end
    end
  end

  assign result    = resultReg;
  assign stall_req = start & ~ready & ~annul;

endmodule

// File: tb/tb_div_unit.sv
// Purpose: randomized + directed check of div_unit against an arithmetic reference.
// Latency: expects ready 33 cycles after accept (2 for divide-by-zero).
// Backpressure: driver holds start until ready, scoreboard monitor checks each ready pulse.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] res;
    int          cycle;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] lastExp = 64'h0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  // Cycle index: value seen between two rising edges
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain MIPS DIV/DIVU arithmetic, {remainder, quotient}
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (resetn === 1'b1 && ready === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got ready=1 with result %h expected no ready (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("ready_cycle", 64'(cyc), 64'(e.cycle));
      end
    end
  end

  // Issue one division, hold start until ready, optionally scramble inputs after accept
  task automatic runDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit scramble);
    exp_t e;
    bit   got;
    int   w;
    @(posedge clk); #1;
    start      = 1'b1;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    annul      = 1'b0;
    e.res      = refDiv(sgn, a, b);
    e.cycle    = cyc + ((b == 32'h0) ? 2 : 33);
    sbq.push_back(e);
    lastExp    = e.res;
    got = 0;
    w   = 0;
    while (!got && w < 40) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        got = 1;
        chk("stall_at_ready", {63'h0, stall_req}, 64'h0);
      end else begin
        chk("stall_busy", {63'h0, stall_req}, 64'h1);
        if (scramble && w >= 1) begin
          opdata1    = $urandom;
          opdata2    = $urandom;
          signed_div = 1'($urandom_range(0, 1));
        end
      end
      w++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no ready expected ready by cycle %0d", e.cycle);
      void'(sbq.pop_back());
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        sgn;
    logic [31:0] a, b;
    resetn     = 1'b0;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'h0;
    opdata2    = 32'h0;
    #1;
    chk("reset_ready", {63'h0, ready}, 64'h0);
    chk("reset_result", result, 64'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Directed cases
    runDiv(1'b0, 32'd100, 32'd7, 1'b0);
    runDiv(1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0);
    runDiv(1'b1, 32'h7, 32'hFFFF_FFFE, 1'b0);
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    runDiv(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    runDiv(1'b0, 32'h1234, 32'h0, 1'b0);
    runDiv(1'b1, 32'h8000_0001, 32'h0, 1'b1);

    // Annul in ON at cycle 10; new start at cycle 12 completes at cycle 45
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b1;
    #1 chk("stall_annul", {63'h0, stall_req}, 64'h0);
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    chk("annul_no_ready", {63'h0, ready}, 64'h0);
    chk("annul_result_held", result, lastExp);
    runDiv(1'b0, 32'd100, 32'd7, 1'b0);

    // Annul during END suppresses ready
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'h55; opdata2 = 32'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    annul = 1'b1;
    #1 chk("end_annul_ready", {63'h0, ready}, 64'h0);
    lastExp = refDiv(1'b0, 32'h55, 32'h0);
    @(posedge clk); #1;
    annul = 1'b0;
    repeat (3) @(posedge clk);

    // Simultaneous start and annul in IDLE: nothing accepted
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1; opdata1 = 32'd5; opdata2 = 32'd1;
    #1 chk("idle_annul_stall", {63'h0, stall_req}, 64'h0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("idle_annul_result", result, lastExp);

    // Reset mid-division clears outputs at once and returns to IDLE
    @(posedge clk); #1;
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd999; opdata2 = 32'd3;
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midreset_ready", {63'h0, ready}, 64'h0);
    chk("midreset_result", result, 64'h0);
    start = 1'b0;
    lastExp = 64'h0;
    @(posedge clk); #1 resetn = 1'b1;
    runDiv(1'b1, 32'hFFFF_FF00, 32'd7, 1'b0);

    // Randomized divisions with operand scrambling after accept
    for (int i = 0; i < 25; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       b = a >> $urandom_range(1, 31);
        default: b = $urandom;
      endcase
      runDiv(sgn, a, b, 1'b1);
    end

    repeat (5) @(posedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL pending: got %0d outstanding results expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for MIPS DIV/DIVU, placed in the EX stage beside the ALU. The ALU's single-cycle multiplier supplies `hilo_temp` for MULT/MULTU; this block supplies the division result on the same 64-bit HI/LO write path as `{remainder, quotient}`. It is a radix-2 restoring divider with a 4-state FSM. It holds the pipeline with a stall request until the result is ready, and it can be annulled by an exception flush.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  divide request from EX; held high by the pipeline until `ready` is seen.
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled at accept.
- `opdata1`  in  32  dividend (rs); sampled at accept.
- `opdata2`  in  32  divisor (rt); sampled at accept.
- `annul`  in  1  flush (exception or ERET); aborts any division in flight.
- `result`  out  64  `{remainder[31:0], quotient[31:0]}`, written to `{HI, LO}`.
- `ready`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `stall_req`  out  1  combinational: `start & ~ready & ~annul`.

## Operation
- States are IDLE, DIVZERO, ON and END, encoded in 2 bits.
- **Accept:** in IDLE, if `start=1` and `annul=0`, the block latches the operands and `signed_div`.
  - If `opdata2==0`, next state is DIVZERO.
  - Otherwise next state is ON, the iteration counter is cleared, and the partial remainder is loaded as `{32'b0, |dividend|}`.
- **Operand magnitude:** in signed mode, a negative operand is replaced by its two's complement (`~x+1`) before dividing. In unsigned mode, operands are used as-is.
- **ON (32 cycles):** each cycle:
  - Shift the 65-bit working register left by 1.
  - Trial-subtract `|divisor|` from the upper 33 bits.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Increment the counter. The cycle in which the counter reaches 31 is the last one, and the next state is END.
- **Sign fix-up, applied when entering END:**
  - The quotient is negated if `signed_div` and the operand signs differ.
  - The remainder is negated if `signed_div` and the dividend is negative.
  - Result: the remainder takes the dividend's sign and the quotient truncates toward zero.
- **Signed overflow case:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. No trap is raised.
- **DIVZERO:** result is `{dividend, 32'hFFFF_FFFF}`, then next state is END. No exception is raised.
- **END:** `ready=1` and `result` is driven from the result register. Next state is always IDLE.
- `result` holds its value until the next END; it is not cleared in IDLE.
- **Annul:** in DIVZERO, ON or END, `annul=1` forces next state to IDLE. In that case:
  - `ready` stays 0 in that cycle.
  - The result register is not updated.
  - In END, `annul` also suppresses `ready`.
- A `start` that arrives while not in IDLE is ignored (no queueing). Operand changes after accept are ignored.
- The pipeline must drop `start` in the cycle after it sees `ready`. If `start` is still high in IDLE, a new division is accepted.

## Timing
- **Reset values:** state=IDLE, counter=0, working register=0, result=0, ready=0. `stall_req` follows its inputs combinationally.
- Reset is asynchronous and takes effect mid-division; there is no output glitch beyond `ready`/`result` going to 0.
- Timing is counted from the accept cycle (cycle 0, `start` high in IDLE):
  - Normal divide: ON in cycles 1–32, END (`ready=1`) in cycle 33.
  - Divide by zero: DIVZERO in cycle 1, END (`ready=1`) in cycle 2.
- `stall_req` is high from cycle 0 until the `ready` cycle, where it drops. The EX instruction advances at the end of the `ready` cycle.
- **Simultaneous `annul` and `start` in IDLE:** annul wins and nothing is accepted.

## Test plan
- **DIVU:** 100 / 7 → `ready` in cycle 33, result = {0x00000002, 0x0000000E}. `stall_req` is high in cycles 0–32 and low in cycle 33.
- **DIV signed:**
  - −7 / 2 (0xFFFFFFF9, 0x2) → {0xFFFFFFFF, 0xFFFFFFFD}.
  - 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- **Boundaries:**
  - DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
  - DIVU 0xFFFFFFFF / 0x1 → {0x00000000, 0xFFFFFFFF}.
- **Divide by zero:** DIVU 0x1234 / 0 → `ready` in cycle 2, result = {0x00001234, 0xFFFFFFFF}.
- **Annul mid-operation:**
  - Start DIVU 100 / 7, assert `annul` in cycle 10 → no `ready`, state IDLE in cycle 11, `result` keeps its prior value.
  - A new start in cycle 12 completes correctly in cycle 45.
- **Reset and ignored starts:**
  - Deassert `resetn` during ON → all outputs 0 immediately, state IDLE.
  - Pulsing `start` with new operands during ON has no effect on the result.
